// File: rtl/tcdm_bank_responder.sv
// ---------------------------------------------------------------------------
// tcdm_bank_responder
//
// Memory-side responder for one TCDM bank. Terminates one HCI bank port from
// the cluster interconnect and drives a single-port SRAM macro whose read
// data appears one cycle after the access. Every granted request gets exactly
// one response one cycle later, carrying the request ID. Write responses
// carry zero data.
//
// Optional feature (macro TCDM_BANK_TS_EN):
//   A read with add_i[TEST_SET_BIT] set is a test-and-set. The old word is
//   returned, and the following cycle writes all ones to the same word. No
//   grant is given in that cycle. Without the macro the flag bit is ignored
//   and every read is a plain read.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   req_i / gnt_o       request valid / grant (combinational)
//   add_i, wen_i        byte address, 1 = read / 0 = write
//   data_i, be_i, id_i  write data, byte enables, request ID
//   r_valid_o, r_data_o, r_id_o
//                       response (valid and ID registered, data is the SRAM
//                       output gated by the registered read flag)
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
//                       SRAM access (combinational)
//   mem_rdata_i         SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module tcdm_bank_responder #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ADDR_MEM_WIDTH = 11,
  parameter int unsigned TEST_SET_BIT   = 20,
  parameter int unsigned ID_WIDTH       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     add_i,
  input  logic                      wen_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic [BE_WIDTH-1:0]       be_i,
  input  logic [ID_WIDTH-1:0]       id_i,
  output logic                      r_valid_o,
  output logic [DATA_WIDTH-1:0]     r_data_o,
  output logic [ID_WIDTH-1:0]       r_id_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_MEM_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  // Word address: byte offset dropped, everything above the SRAM range
  // (including the test-and-set flag) ignored for addressing.
  logic [ADDR_MEM_WIDTH-1:0] word_addr;
  logic                      ts_flag;
  logic                      grant;
  logic                      is_read_p1;

  assign word_addr = add_i[ADDR_MEM_WIDTH+1:2];
  assign ts_flag   = add_i[TEST_SET_BIT];

`ifdef TCDM_BANK_TS_EN

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } state_e;

  state_e                    state;
  state_e                    state_nxt;
  logic                      ts_start;
  logic [ADDR_MEM_WIDTH-1:0] ts_addr_p1;

  logic unused_addr;
  assign unused_addr = ^{add_i[ADDR_WIDTH-1:ADDR_MEM_WIDTH+2], add_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The test-and-set target is only meaningful while in TS_WR, so the latch
  // carries no reset.
  always_ff @(posedge clk_i) begin
    if (ts_start) begin
      ts_addr_p1 <= word_addr;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    ts_start    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = word_addr;
    mem_wdata_o = data_i;
    mem_be_o    = be_i;
    unique case (state)
      IDLE: begin
        grant     = req_i & rst_ni;
        mem_req_o = grant;
        mem_we_o  = ~wen_i;
        // Only reads start the atomic sequence; a flagged write is plain.
        ts_start  = grant & wen_i & ts_flag;
        if (ts_start) begin
          state_nxt = TS_WR;
        end
      end
      TS_WR: begin
        // Reset in this cycle suppresses the all-ones write.
        mem_req_o   = rst_ni;
        mem_we_o    = 1'b1;
        mem_addr_o  = ts_addr_p1;
        mem_wdata_o = '1;
        mem_be_o    = '1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`else

  logic unused_addr;
  assign unused_addr = ^{add_i[ADDR_WIDTH-1:ADDR_MEM_WIDTH+2], add_i[1:0], ts_flag};

  always_comb begin
    grant       = req_i & rst_ni;
    mem_req_o   = grant;
    mem_we_o    = ~wen_i;
    mem_addr_o  = word_addr;
    mem_wdata_o = data_i;
    mem_be_o    = be_i;
  end

`endif

  assign gnt_o = grant;

  // ---- stage p0 -> p1: response register, rewritten every cycle ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid_o  <= 1'b0;
      r_id_o     <= '0;
      is_read_p1 <= 1'b0;
    end else begin
      r_valid_o  <= grant;
      is_read_p1 <= grant & wen_i;
      if (grant) begin
        r_id_o <= id_i;
      end
    end
  end

  // The SRAM output is itself registered inside the macro; writes and idle
  // cycles return zero.
  assign r_data_o = is_read_p1 ? mem_rdata_i : '0;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Self-checking bench for tcdm_bank_responder: directed scenarios followed by
// randomized traffic, checked against a word-array reference model.
module tb_tcdm_bank_responder;

  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int AW  = 32;
  localparam int MW  = 11;
  localparam int TSB = 20;
  localparam int IW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_i, gnt_o, wen_i;
  logic [AW-1:0] add_i;
  logic [DW-1:0] data_i;
  logic [BW-1:0] be_i;
  logic [IW-1:0] id_i;
  logic          r_valid_o;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;
  logic          mem_req_o, mem_we_o;
  logic [MW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata_i;

  always #5 clk = ~clk;

  tcdm_bank_responder #(
    .DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW),
    .ADDR_MEM_WIDTH(MW), .TEST_SET_BIT(TSB), .ID_WIDTH(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i), .id_i(id_i),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM macro: 1-cycle read latency, byte-enabled writes.
  logic [DW-1:0] sram [0:(1<<MW)-1];
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
      else          mem_rdata_i <= sram[mem_addr_o];
    end
  end

  // Reference model: memory contents and the response expected next cycle.
  logic [DW-1:0] ref_mem [0:(1<<MW)-1];
  bit            m_vld = 1'b0;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;
  bit            m_ts = 1'b0;
  int            m_ts_addr;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] obs_data;
  logic [IW-1:0] obs_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic req, input logic wen, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [BW-1:0] be,
                      input logic [IW-1:0] id, output logic granted);
    logic exp_gnt;
    int   w;
    req_i = req; wen_i = wen; add_i = addr; data_i = data; be_i = be; id_i = id;
    @(negedge clk);
    w       = int'(addr[MW+1:2]);
    exp_gnt = req && rst_n && !m_ts;
    chk("gnt", gnt_o, exp_gnt);
    chk("mem_req", mem_req_o, exp_gnt || (m_ts && rst_n));
    if (exp_gnt) begin
      chk("mem_we", mem_we_o, !wen);
      chk("mem_addr", mem_addr_o, w);
    end else if (m_ts && rst_n) begin
      chk("ts_write", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o},
          {1'b1, m_ts_addr[MW-1:0], 4'hF, 32'hFFFF_FFFF});
    end
    chk("r_valid", r_valid_o, m_vld);
    if (m_vld) begin
      chk("r_data", r_data_o, m_data);
      chk("r_id", r_id_o, m_id);
      obs_data = r_data_o;
      obs_id   = r_id_o;
    end
    granted = gnt_o;
    if (!rst_n) begin
      m_vld = 1'b0;
      m_ts  = 1'b0;
    end else begin
      if (m_ts) begin
        ref_mem[m_ts_addr] = '1;
        m_ts = 1'b0;
      end
      m_vld = exp_gnt;
      if (exp_gnt) begin
        m_id = id;
        if (wen) begin
          m_data = ref_mem[w];
`ifdef TCDM_BANK_TS_EN
          m_ts      = addr[TSB];
          m_ts_addr = w;
`endif
        end else begin
          m_data     = '0;
          ref_mem[w] = merge(ref_mem[w], data, be);
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Hold a request until granted, as the initiator must.
  task automatic issue(input logic wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [BW-1:0] be,
                       input logic [IW-1:0] id);
    logic g;
    int   n = 0;
    do begin
      step(1'b1, wen, addr, data, be, id, g);
      n++;
    end while (!g && n < 4);
    if (!g) chk("grant_timeout", g, 1'b1);
  endtask

  task automatic idle();
    logic g;
    step(1'b0, 1'b1, '0, '0, '0, '0, g);
  endtask

  function automatic logic [AW-1:0] wa(input int word, input bit ts);
    logic [AW-1:0] a;
    a = AW'(word) << 2;
    a[TSB] = ts;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic g;
    int   c0;
    rst_n = 1'b0; req_i = 1'b1; wen_i = 1'b1; add_i = '0; data_i = '0; be_i = '0; id_i = '0;

    // Reset: no grant or SRAM access while asserted, response cleared.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_r_valid", r_valid_o, 1'b0);
    chk("rst_r_id", r_id_o, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_i = 1'b0;

    // Known contents for the words used below.
    for (int i = 0; i < 16; i++) issue(1'b0, wa(i, 0), $urandom, 4'hF, IW'(i));

    // Write then read.
    issue(1'b0, wa(5, 0), 32'hDEAD_BEEF, 4'hF, 8'd3);
    issue(1'b1, wa(5, 0), '0, '0, 8'd7);
    chk("wr_rsp", {obs_id, obs_data}, {8'd3, 32'h0});
    idle();
    chk("rd_rsp", {obs_id, obs_data}, {8'd7, 32'hDEAD_BEEF});

    // Byte enables.
    issue(1'b0, wa(5, 0), 32'h1122_3344, 4'h5, 8'd8);
    issue(1'b1, wa(5, 0), '0, '0, 8'd9);
    idle();
    chk("be_merge", obs_data, 32'hDE22_BE44);

    // Test-and-set followed immediately by a plain read of the same word.
    issue(1'b0, wa(9, 0), 32'h0, 4'hF, 8'd1);
    issue(1'b1, wa(9, 1), '0, '0, 8'd2);
    step(1'b1, 1'b1, wa(9, 0), '0, '0, 8'd4, g);
    chk("ts_old_value", {obs_id, obs_data}, {8'd2, 32'h0});
`ifdef TCDM_BANK_TS_EN
    chk("ts_gnt_bubble", g, 1'b0);
    step(1'b1, 1'b1, wa(9, 0), '0, '0, 8'd4, g);
    chk("ts_late_gnt", g, 1'b1);
    idle();
    chk("ts_after", obs_data, 32'hFFFF_FFFF);
`else
    chk("no_bubble", g, 1'b1);
    idle();
    chk("ts_off_unchanged", obs_data, 32'h0);
`endif

    // Streaming reads: one grant per cycle, responses in order.
    c0 = cyc;
    for (int i = 0; i < 16; i++) issue(1'b1, wa(i, 0), '0, '0, IW'(i));
    chk("stream_cycles", cyc - c0, 16);
    idle();
    chk("stream_last_id", obs_id, 8'd15);

    // Reset in the cycle after a test-and-set grant.
    issue(1'b0, wa(12, 0), 32'hA5A5_5A5A, 4'hF, 8'd5);
    issue(1'b1, wa(12, 1), '0, '0, 8'd6);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    idle();
    chk("rst_ts_r_valid", r_valid_o, 1'b0);
    issue(1'b1, wa(12, 0), '0, '0, 8'd7);
    idle();
    chk("rst_ts_word_kept", obs_data, 32'hA5A5_5A5A);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) idle();
      issue(1'($urandom), wa($urandom_range(0, 15), 1'($urandom)),
            $urandom, 4'($urandom), 8'($urandom));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
